uart_rx_param: RTL and testbench

Parametrised UART receive engine: it turns a serial line into parallel words with configurable word width, parity and stop bits, at a run-time baud divisor. It checks each frame and returns the result through a single-entry valid/ready output buffer with error status. It is the next-generation drop-in for the fixed 8-bit receive path. It sits between the board-level rx pin and the packet/command layer.

---
 rtl/uart_rx_param_if.sv | 22 ++
 rtl/uart_rx_param.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_param_if.sv
// Receive-side output buffer bus: received word, frame status and valid/ready handshake.
interface uart_rx_param_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              parity_err;
  logic              frame_err;
  logic              break_det;
  logic              overrun;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, break_det, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, break_det, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised rx line, mid-bit sampling at a run-time
// baud divisor, parity/stop checking and a single-entry valid/ready result buffer.
module uart_rx_param #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BAUD_W     = 20,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [BAUD_W-1:0] baud,
  input  logic              rx_in,
  uart_rx_param_if.master   rx,
  output logic              busy,
  output logic [3:0]        bit_cnt_out
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  localparam logic [3:0]        LAST_DATA = 4'(DATA_W - 1);
  localparam logic [3:0]        LAST_STOP = 4'(DATA_W + PARITY_EN + STOP_BITS - 1);
  localparam logic [3:0]        CNT_MAX   = 4'(DATA_W + 2);
  localparam logic [BAUD_W-1:0] BAUD_MIN  = BAUD_W'(4);

  logic              sync1;
  logic              rxs;
  state_t            state;
  logic [BAUD_W-1:0] cnt;
  logic [3:0]        bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              pbit;
  logic              ferr_acc;

  logic [BAUD_W-1:0] baud_eff_c;
  logic              tick_c;
  logic [3:0]        bit_cnt_inc_c;
  logic              done_c;
  logic              ferr_c;
  logic              perr_c;
  logic              brk_c;

  assign baud_eff_c    = (baud < BAUD_MIN) ? BAUD_MIN : baud;
  // Tick on the count of 1 so the sample spacing is exactly baud clocks.
  assign tick_c        = (cnt <= BAUD_W'(1));
  assign bit_cnt_inc_c = (bit_cnt >= CNT_MAX) ? CNT_MAX : bit_cnt + 4'd1;
  assign done_c        = en && (state == STOP) && tick_c && (bit_cnt == LAST_STOP);
  assign ferr_c        = ferr_acc | ~rxs;
  assign perr_c        = (PARITY_EN != 0) ? ((^shreg) ^ pbit ^ 1'(PARITY_ODD)) : 1'b0;
  assign brk_c         = ferr_c && (shreg == '0) && !pbit;
  assign bit_cnt_out   = bit_cnt;

  // Two-flop synchroniser, idle-high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rxs   <= sync1;
    end
  end

  // Frame FSM with baud counter, bit counter and shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      pbit     <= 1'b0;
      ferr_acc <= 1'b0;
    end else if (!en) begin
      state   <= IDLE;
      busy    <= 1'b0;
      bit_cnt <= '0;
    end else begin
      if (state != IDLE && state != WAIT_HIGH) begin
        cnt <= tick_c ? baud_eff_c : cnt - BAUD_W'(1);
      end
      case (state)
        IDLE: begin
          if (!rxs) begin
            cnt     <= baud_eff_c >> 1;
            state   <= START;
            busy    <= 1'b1;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (tick_c) begin
            if (rxs) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state    <= DATA;
              bit_cnt  <= '0;
              pbit     <= 1'b0;
              ferr_acc <= 1'b0;
            end
          end
        end
        DATA: begin
          if (tick_c) begin
            shreg   <= {rxs, shreg[DATA_W-1:1]};
            bit_cnt <= bit_cnt_inc_c;
            if (bit_cnt == LAST_DATA) state <= (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (tick_c) begin
            pbit    <= rxs;
            bit_cnt <= bit_cnt_inc_c;
            state   <= STOP;
          end
        end
        STOP: begin
          if (tick_c) begin
            bit_cnt <= bit_cnt_inc_c;
            if (!rxs) ferr_acc <= 1'b1;
            if (bit_cnt == LAST_STOP) begin
              state <= rxs ? IDLE : WAIT_HIGH;
              busy  <= ~rxs;
              if (rxs) bit_cnt <= '0;
            end
          end
        end
        WAIT_HIGH: begin
          if (rxs) begin
            state   <= IDLE;
            busy    <= 1'b0;
            bit_cnt <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Single-entry result buffer; a same-cycle handshake frees it for the new frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx.rx_data    <= '0;
      rx.rx_valid   <= 1'b0;
      rx.parity_err <= 1'b0;
      rx.frame_err  <= 1'b0;
      rx.break_det  <= 1'b0;
      rx.overrun    <= 1'b0;
    end else begin
      rx.overrun <= 1'b0;
      if (done_c && (!rx.rx_valid || rx.rx_ready)) begin
        rx.rx_data    <= shreg;
        rx.rx_valid   <= 1'b1;
        rx.parity_err <= perr_c;
        rx.frame_err  <= ferr_c;
        rx.break_det  <= brk_c;
      end else if (done_c) begin
        rx.overrun <= 1'b1;
      end else if (rx.rx_valid && rx.rx_ready) begin
        rx.rx_valid   <= 1'b0;
        rx.parity_err <= 1'b0;
        rx.frame_err  <= 1'b0;
        rx.break_det  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance and a 7-bit even-parity two-stop instance.
module tb_uart_rx_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b1;
  logic [19:0] baud8 = 20'd16;
  logic [19:0] baud7 = 20'd8;
  logic        rx8 = 1'b1;
  logic        rx7 = 1'b1;
  logic        busy8, busy7;
  logic [3:0]  bcnt8, bcnt7;

  int n_tests = 0;
  int n_fail  = 0;
  int ovr_cnt = 0;
  bit busy_seen = 1'b0;

  uart_rx_param_if #(.DATA_W(8)) if8 ();
  uart_rx_param_if #(.DATA_W(7)) if7 ();

  uart_rx_param #(.DATA_W(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .baud(baud8), .rx_in(rx8),
    .rx(if8), .busy(busy8), .bit_cnt_out(bcnt8)
  );

  uart_rx_param #(.DATA_W(7), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut7 (
    .clk(clk), .rst(rst), .en(en), .baud(baud7), .rx_in(rx7),
    .rx(if7), .busy(busy7), .bit_cnt_out(bcnt7)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (if8.overrun || if7.overrun) ovr_cnt = ovr_cnt + 1;
    if (busy8) busy_seen = 1'b1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    bit         sel;
    int         bt;
    logic [19:0] baud;
    logic [8:0] data;
    bit         pb;
    logic [1:0] stopv;
    logic [8:0] exp_data;
    bit         exp_pe;
    bit         exp_fe;
    bit         exp_bk;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mk_frame(input bit sel, input logic [8:0] d, input bit pb,
                                           input logic [1:0] st);
    logic [15:0] v;
    int idx;
    v = 16'hFFFF;
    v[0] = 1'b0;
    for (int i = 0; i < (sel ? 7 : 8); i++) v[1+i] = d[i];
    idx = sel ? 8 : 9;
    if (sel) begin
      v[idx] = pb;
      idx++;
    end
    v[idx] = st[0];
    if (sel) v[idx+1] = st[1];
    return v;
  endfunction

  task automatic send_bits(input bit sel, input logic [15:0] v, input int n, input int bt);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (sel) rx7 = v[i]; else rx8 = v[i];
      repeat (bt) @(negedge clk);
    end
    if (sel) rx7 = 1'b1; else rx8 = 1'b1;
  endtask

  task automatic send8(input logic [7:0] d);
    send_bits(1'b0, mk_frame(1'b0, {1'b0, d}, 1'b0, 2'b11), 10, 16);
  endtask

  task automatic wait_valid(input bit sel, input int max);
    int k = 0;
    while (!(sel ? if7.rx_valid : if8.rx_valid) && k < max) begin
      @(negedge clk);
      k++;
    end
    check("wait_valid", 32'(sel ? if7.rx_valid : if8.rx_valid), 32'd1);
  endtask

  task automatic handshake(input bit sel);
    @(negedge clk);
    if (sel) if7.rx_ready = 1'b1; else if8.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hs_valid_clear", 32'(sel ? if7.rx_valid : if8.rx_valid), 32'd0);
    check("hs_flags_clear", sel ? 32'({if7.parity_err, if7.frame_err, if7.break_det})
                                : 32'({if8.parity_err, if8.frame_err, if8.break_det}), 32'd0);
    @(negedge clk);
    if (sel) if7.rx_ready = 1'b0; else if8.rx_ready = 1'b0;
  endtask

  vec_t vecs[11];
  int   ovr_base;

  initial begin
    if8.rx_ready = 1'b0;
    if7.rx_ready = 1'b0;
    //          sel bt baud  data    pb stop   exp    pe fe bk
    vecs[0]  = '{0, 16, 16, 9'hA5, 0, 2'b11, 9'hA5, 0, 0, 0};
    vecs[1]  = '{0, 16, 16, 9'h00, 0, 2'b11, 9'h00, 0, 0, 0};
    vecs[2]  = '{0,  4,  4, 9'hFF, 0, 2'b11, 9'hFF, 0, 0, 0};
    vecs[3]  = '{0,  4,  3, 9'h5A, 0, 2'b11, 9'h5A, 0, 0, 0};
    vecs[4]  = '{0, 16, 16, 9'h55, 0, 2'b10, 9'h55, 0, 1, 0};
    vecs[5]  = '{1,  8,  8, 9'h41, 0, 2'b11, 9'h41, 0, 0, 0};
    vecs[6]  = '{1,  8,  8, 9'h41, 1, 2'b11, 9'h41, 1, 0, 0};
    vecs[7]  = '{1,  8,  8, 9'h7F, 1, 2'b11, 9'h7F, 0, 0, 0};
    vecs[8]  = '{1,  8,  8, 9'h00, 0, 2'b01, 9'h00, 0, 1, 1};
    vecs[9]  = '{1,  8,  8, 9'h00, 1, 2'b10, 9'h00, 1, 1, 0};
    vecs[10] = '{1, 12, 12, 9'h2A, 1, 2'b11, 9'h2A, 0, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_data",  32'(if8.rx_data), 32'd0);
    check("rst_valid", 32'({if8.rx_valid, if7.rx_valid}), 32'd0);
    check("rst_flags", 32'({if8.parity_err, if8.frame_err, if8.break_det, if8.overrun}), 32'd0);
    check("rst_busy",  32'({busy8, busy7}), 32'd0);
    check("rst_bcnt",  32'(bcnt8), 32'd0);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Exact 8N1 timing for 0xA5 at baud 16.
    fork
      send8(8'hA5);
      begin
        @(negedge clk);
        @(posedge clk);
        repeat (100) @(posedge clk);
        #1;
        check("mid_bitcnt", 32'(bcnt8), 32'd5);
        check("mid_busy", 32'(busy8), 32'd1);
        repeat (53) @(posedge clk);
        #1;
        check("valid_t154", 32'(if8.rx_valid), 32'd0);
        @(posedge clk);
        #1;
        check("valid_t155", 32'(if8.rx_valid), 32'd1);
      end
    join
    check("a5_data", 32'(if8.rx_data), 32'hA5);
    check("a5_flags", 32'({if8.parity_err, if8.frame_err, if8.break_det}), 32'd0);
    handshake(1'b0);
    repeat (10) @(negedge clk);

    foreach (vecs[i]) begin
      if (vecs[i].sel) baud7 = vecs[i].baud; else baud8 = vecs[i].baud;
      send_bits(vecs[i].sel, mk_frame(vecs[i].sel, vecs[i].data, vecs[i].pb, vecs[i].stopv),
                vecs[i].sel ? 11 : 10, vecs[i].bt);
      wait_valid(vecs[i].sel, 200);
      check($sformatf("v%0d_data", i), vecs[i].sel ? 32'(if7.rx_data) : 32'(if8.rx_data),
            32'(vecs[i].exp_data));
      check($sformatf("v%0d_perr", i), 32'(vecs[i].sel ? if7.parity_err : if8.parity_err),
            32'(vecs[i].exp_pe));
      check($sformatf("v%0d_ferr", i), 32'(vecs[i].sel ? if7.frame_err : if8.frame_err),
            32'(vecs[i].exp_fe));
      check($sformatf("v%0d_brk", i), 32'(vecs[i].sel ? if7.break_det : if8.break_det),
            32'(vecs[i].exp_bk));
      handshake(vecs[i].sel);
      repeat (20) @(negedge clk);
    end
    baud8 = 20'd16;

    // Three-cycle low glitch is a false start.
    ovr_base = ovr_cnt;
    busy_seen = 1'b0;
    @(negedge clk);
    rx8 = 1'b0;
    repeat (3) @(negedge clk);
    rx8 = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_busy_seen", 32'(busy_seen), 32'd1);
    check("glitch_idle", 32'(busy8), 32'd0);
    check("glitch_valid", 32'(if8.rx_valid), 32'd0);
    check("glitch_ovr", 32'(ovr_cnt - ovr_base), 32'd0);

    // Break: line low for 12 bit times.
    send_bits(1'b0, 16'h0000, 12, 16);
    #1;
    check("brk_valid", 32'(if8.rx_valid), 32'd1);
    check("brk_data", 32'(if8.rx_data), 32'd0);
    check("brk_flags", 32'({if8.frame_err, if8.break_det, if8.parity_err}), 32'b110);
    check("brk_busy_low", 32'(busy8), 32'd1);
    repeat (10) @(negedge clk);
    check("brk_busy_high", 32'(busy8), 32'd0);
    handshake(1'b0);

    // Overrun: second frame dropped while the first is held.
    ovr_base = ovr_cnt;
    send8(8'h11);
    send8(8'h22);
    repeat (5) @(negedge clk);
    check("ovr_count", 32'(ovr_cnt - ovr_base), 32'd1);
    check("ovr_valid", 32'(if8.rx_valid), 32'd1);
    check("ovr_data", 32'(if8.rx_data), 32'h11);
    handshake(1'b0);

    // Same-cycle handshake frees the buffer for the new frame.
    ovr_base = ovr_cnt;
    send8(8'h11);
    wait_valid(1'b0, 50);
    fork
      send8(8'h22);
      begin
        @(negedge clk);
        @(posedge clk);
        repeat (153) @(posedge clk);
        @(negedge clk);
        if8.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hs_same_valid", 32'(if8.rx_valid), 32'd1);
        check("hs_same_data", 32'(if8.rx_data), 32'h22);
        @(negedge clk);
        if8.rx_ready = 1'b0;
      end
    join
    check("hs_same_ovr", 32'(ovr_cnt - ovr_base), 32'd0);
    handshake(1'b0);

    // Reset mid-frame with a word held.
    send8(8'h5A);
    wait_valid(1'b0, 50);
    fork
      send8(8'h99);
      begin
        repeat (60) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst_valid", 32'(if8.rx_valid), 32'd0);
        check("mrst_data", 32'(if8.rx_data), 32'd0);
        check("mrst_busy", 32'(busy8), 32'd0);
        check("mrst_bcnt", 32'(bcnt8), 32'd0);
      end
    join
    rst = 1'b1;
    repeat (10) @(negedge clk);
    send8(8'h3C);
    wait_valid(1'b0, 50);
    check("post_rst_data", 32'(if8.rx_data), 32'h3C);
    handshake(1'b0);

    // Enable dropped mid-frame discards the frame.
    fork
      send8(8'h77);
      begin
        repeat (60) @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("en_busy", 32'(busy8), 32'd0);
        check("en_bcnt", 32'(bcnt8), 32'd0);
      end
    join
    repeat (5) @(negedge clk);
    en = 1'b1;
    repeat (5) @(negedge clk);
    check("en_valid", 32'(if8.rx_valid), 32'd0);
    send8(8'h3C);
    wait_valid(1'b0, 50);
    check("post_en_data", 32'(if8.rx_data), 32'h3C);
    check("post_en_flags", 32'({if8.parity_err, if8.frame_err, if8.break_det}), 32'd0);
    handshake(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
